// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and constants for the lockstep fault-tolerance monitor
//
// Purpose: FSM state type, recovery-map constants and a byte-enable merge helper
//          used by cevero_ft_module and ft_shadow_regfile.
// Ports:   none (package).

package ft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESET   = 2'd1,
        RECOVER = 2'd2
    } ft_state_e;

    // Byte offset of the checkpoint-PC word inside the recovery map.
    localparam logic [7:0] PC_OFFSET = 8'h80;

    // Architectural register count including x0.
    localparam int REG_WORDS = 32;

    // Replace only the bytes selected by be, keep the rest of the old word.
    function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ft_shadow_regfile.sv
// rtl/ft_shadow_regfile.sv - golden shadow copy of registers x1..x31
//
// Purpose: holds the last matched architectural register values.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset (clears x1..x31)
//   i_commit_we/addr/data   commit write port fed by matched core writes
//   i_rec_we/be/addr/wdata  recovery write port with per-byte enables
//   o_rec_rdata             combinational read at i_rec_addr (x0 reads 0)

module ft_shadow_regfile
    import ft_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_commit_we,
    input  logic [4:0]  i_commit_addr,
    input  logic [31:0] i_commit_data,
    input  logic        i_rec_we,
    input  logic [3:0]  i_rec_be,
    input  logic [4:0]  i_rec_addr,
    input  logic [31:0] i_rec_wdata,
    output logic [31:0] o_rec_rdata
);

    // x0 has no storage; it is hardwired to zero on the read side.
    logic [31:0] r_regs [1:REG_WORDS-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 1; i < REG_WORDS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_WORDS; i++) begin
                // The two ports are never active together in practice (commit
                // only in IDLE, recovery only in RECOVER); commit wins anyway.
                if (i_commit_we && i_commit_addr == 5'(i)) begin
                    r_regs[i] <= i_commit_data;
                end else if (i_rec_we && i_rec_addr == 5'(i)) begin
                    r_regs[i] <= merge_be(r_regs[i], i_rec_wdata, i_rec_be);
                end
            end
        end
    end

    always_comb begin
        o_rec_rdata = '0;
        if (i_rec_addr != 5'd0) begin
            o_rec_rdata = r_regs[i_rec_addr];
        end
    end

endmodule

// File: rtl/cevero_ft_module.sv
// rtl/cevero_ft_module.sv - dual-lockstep compare, checkpoint and recovery controller
//
// Purpose: compares the regfile write ports of two lockstep cores, keeps a golden
//          shadow regfile and checkpoint PC, and on a mismatch (or forced error)
//          resets both cores, raises a debug request and serves the shadow state
//          over a slave data port until the debug routine reports done.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   we/addr/data_a_i, _b_i        regfile write ports of core A and core B
//   pc_i, valid_instr_exec_i      checkpoint PC source and its qualifier
//   enable_i, force_error_i       checking enable, error injection
//   data_req/we/be/addr/wdata_i   recovery slave port request
//   data_gnt/rvalid/rdata/err_o   recovery slave port response
//   done_i                        recovery routine finished
//   recover_o, reset_o            debug request / reset to both cores
//   recovering_o, error_o         data-bus mux select, one-cycle error pulse

module cevero_ft_module
    import ft_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [7:0]  PC_OFFSET = ft_pkg::PC_OFFSET
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [4:0]  addr_a_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic [31:0] pc_i,
    input  logic        enable_i,
    input  logic        valid_instr_exec_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        done_i,
    input  logic        force_error_i,
    output logic        recover_o,
    output logic        reset_o,
    output logic        recovering_o,
    output logic        error_o
);

    ft_state_e   r_state;
    logic        r_error;
    logic [31:0] r_pc;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_rerr;

    logic        w_idle_chk;
    logic        w_mismatch;
    logic        w_err;
    logic        w_ckpt_en;
    logic        w_recovering;
    logic        w_gnt;
    logic        w_hit_pc;
    logic        w_hit_reg;
    logic        w_addr_err;
    logic        w_rec_reg_we;
    logic        w_rec_pc_we;
    logic [31:0] w_shadow_rdata;
    logic        w_unused_addr_hi;

    // Only the low byte of the address selects a word in the recovery map.
    assign w_unused_addr_hi = ^data_addr_i[31:8];

    // ---------------- comparator ----------------
    assign w_idle_chk = (r_state == IDLE) && enable_i;
    assign w_mismatch = (we_a_i != we_b_i) ||
                        (we_a_i && ((addr_a_i != addr_b_i) || (data_a_i != data_b_i)));
    assign w_err      = w_idle_chk && (w_mismatch || force_error_i);
    // A detected (or injected) error blocks the checkpoint of that same cycle.
    assign w_ckpt_en  = w_idle_chk && !w_err;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_error <= 1'b0;
        end else begin
            r_error <= w_err;
            case (r_state)
                IDLE:    if (w_err) r_state <= RESET;
                RESET:   r_state <= RECOVER;
                RECOVER: if (done_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_recovering = (r_state == RECOVER);
    assign error_o      = r_error;
    assign reset_o      = (r_state == RESET);
    assign recover_o    = w_recovering;
    assign recovering_o = w_recovering;

    // ---------------- recovery slave port ----------------
    assign w_gnt      = w_recovering && data_req_i;
    assign w_hit_pc   = (data_addr_i[7:0] == PC_OFFSET);
    assign w_hit_reg  = !data_addr_i[7] && !w_hit_pc;
    assign w_addr_err = (data_addr_i[1:0] != 2'b00) || !(w_hit_pc || w_hit_reg);

    assign w_rec_reg_we = w_gnt && data_we_i && w_hit_reg && !w_addr_err;
    assign w_rec_pc_we  = w_gnt && data_we_i && w_hit_pc  && !w_addr_err;

    // The response is registered independently of the FSM so a request granted
    // in the done_i cycle still gets its rvalid in the following cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_rerr   <= w_gnt && w_addr_err;
            r_rdata  <= '0;
            if (w_gnt && !data_we_i && !w_addr_err) begin
                r_rdata <= w_hit_pc ? r_pc : w_shadow_rdata;
            end
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_rerr;

    // ---------------- checkpoint PC ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc <= PC_RESET;
        end else if (w_ckpt_en && valid_instr_exec_i) begin
            r_pc <= pc_i;
        end else if (w_rec_pc_we) begin
            r_pc <= merge_be(r_pc, data_wdata_i, data_be_i);
        end
    end

    // ---------------- shadow register file ----------------
    ft_shadow_regfile u_shadow (
        .i_clk         (clk_i),
        .i_rst_n       (rst_ni),
        .i_commit_we   (w_ckpt_en && we_a_i),
        .i_commit_addr (addr_a_i),
        .i_commit_data (data_a_i),
        .i_rec_we      (w_rec_reg_we),
        .i_rec_be      (data_be_i),
        .i_rec_addr    (data_addr_i[6:2]),
        .i_rec_wdata   (data_wdata_i),
        .o_rec_rdata   (w_shadow_rdata)
    );

endmodule

// File: tb/tb_cevero_ft_module.sv
// tb/tb_cevero_ft_module.sv - self-checking bench for cevero_ft_module

module tb_cevero_ft_module;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        we_a_i, we_b_i;
    logic [4:0]  addr_a_i, addr_b_i;
    logic [31:0] data_a_i, data_b_i;
    logic [31:0] pc_i;
    logic        enable_i, valid_instr_exec_i;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        done_i, force_error_i;
    logic        recover_o, reset_o, recovering_o, error_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural view of what the monitor should hold.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    cevero_ft_module dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .we_a_i             (we_a_i),
        .we_b_i             (we_b_i),
        .addr_a_i           (addr_a_i),
        .addr_b_i           (addr_b_i),
        .data_a_i           (data_a_i),
        .data_b_i           (data_b_i),
        .pc_i               (pc_i),
        .enable_i           (enable_i),
        .valid_instr_exec_i (valid_instr_exec_i),
        .data_req_i         (data_req_i),
        .data_we_i          (data_we_i),
        .data_be_i          (data_be_i),
        .data_addr_i        (data_addr_i),
        .data_wdata_i       (data_wdata_i),
        .data_gnt_o         (data_gnt_o),
        .data_rvalid_o      (data_rvalid_o),
        .data_rdata_o       (data_rdata_o),
        .data_err_o         (data_err_o),
        .done_i             (done_i),
        .force_error_i      (force_error_i),
        .recover_o          (recover_o),
        .reset_o            (reset_o),
        .recovering_o       (recovering_o),
        .error_o            (error_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Control outputs packed as {error, reset, recover, recovering}.
    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, error_o, reset_o, recover_o, recovering_o}, {28'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_core();
        we_a_i = 0; we_b_i = 0; addr_a_i = 0; addr_b_i = 0;
        data_a_i = 0; data_b_i = 0; pc_i = 0;
        valid_instr_exec_i = 0; force_error_i = 0; enable_i = 1;
    endtask

    // Random core traffic, including mismatches and forced errors; must be
    // ignored whenever the monitor is not in its idle checking phase.
    task automatic core_noise();
        we_a_i = 1'($urandom); we_b_i = 1'($urandom);
        addr_a_i = 5'($urandom); addr_b_i = 5'($urandom);
        data_a_i = $urandom; data_b_i = $urandom; pc_i = $urandom;
        valid_instr_exec_i = 1'($urandom); force_error_i = 1'($urandom);
        enable_i = 1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_pc = 32'h0;
    endtask

    task automatic exp_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        d = 0; e = 0;
        if (a[1:0] != 0) e = 1;
        else if (a[7:0] == 8'h80) d = m_pc;
        else if (a[7:0] < 8'h80) d = m_regs[a[7:0] / 4];
        else e = 1;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        quiet_core();
        done_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
        data_addr_i = 0; data_wdata_i = 0;
        next_cycle();
        next_cycle();
        rst_ni = 1;
        model_clear();
    endtask

    // Idle-phase commit traffic; expected shadow/PC follow the commit rules.
    task automatic run_commits(input int n, input logic en);
        for (int k = 0; k < n; k++) begin
            we_a_i = 1'($urandom); addr_a_i = 5'($urandom); data_a_i = $urandom;
            we_b_i = we_a_i; addr_b_i = addr_a_i; data_b_i = data_a_i;
            if (!en && $urandom_range(0, 1) == 1) begin
                we_b_i = 1; data_b_i = ~data_a_i;
            end
            valid_instr_exec_i = 1'($urandom); pc_i = $urandom;
            enable_i = en; force_error_i = 0;
            @(negedge clk);
            check_ctrl("idle_ctrl", 4'b0000);
            if (en && we_a_i && addr_a_i != 0) m_regs[addr_a_i] = data_a_i;
            if (en && valid_instr_exec_i) m_pc = pc_i;
            next_cycle();
        end
        quiet_core();
    endtask

    task automatic enter_recovery(input logic use_force, input logic [4:0] a,
                                  input logic [31:0] da, input logic [31:0] db);
        enable_i = 1;
        we_a_i = 1; we_b_i = 1; addr_a_i = a; addr_b_i = a;
        data_a_i = da; data_b_i = db;
        force_error_i = use_force; valid_instr_exec_i = 1; pc_i = $urandom;
        @(negedge clk);
        check_ctrl("pre_err_ctrl", 4'b0000);
        next_cycle();
        core_noise();
        @(negedge clk);
        check_ctrl("err_pulse_ctrl", 4'b1100);
        next_cycle();
        core_noise();
        @(negedge clk);
        check_ctrl("recover_ctrl", 4'b0011);
        next_cycle();
    endtask

    task automatic bus_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic with_done);
        logic [31:0] ed;
        logic        ee;
        data_req_i = 1; data_we_i = we; data_be_i = be;
        data_addr_i = addr; data_wdata_i = wdata; done_i = with_done;
        core_noise();
        exp_read(addr, ed, ee);
        @(negedge clk);
        check("gnt", {31'd0, data_gnt_o}, 32'd1);
        if (we && !ee) begin
            logic [31:0] old_w, new_w;
            old_w = (addr[7:0] == 8'h80) ? m_pc : m_regs[addr[7:0] / 4];
            new_w = old_w;
            for (int b = 0; b < 4; b++)
                if (be[b]) new_w[8*b +: 8] = wdata[8*b +: 8];
            if (addr[7:0] == 8'h80) m_pc = new_w;
            else if (addr[7:0] / 4 != 0) m_regs[addr[7:0] / 4] = new_w;
        end
        next_cycle();
        data_req_i = 0; data_we_i = 0; done_i = 0;
        if (with_done) quiet_core();
        else core_noise();
        @(negedge clk);
        check("rvalid", {31'd0, data_rvalid_o}, 32'd1);
        check($sformatf("rerr@%02h", addr[7:0]), {31'd0, data_err_o}, {31'd0, ee});
        if (!we) check($sformatf("rdata@%02h", addr[7:0]), data_rdata_o, ed);
        if (with_done) check_ctrl("done_ctrl", 4'b0000);
        next_cycle();
    endtask

    task automatic verify_all();
        for (int i = 0; i < 32; i++) bus_op(0, 4'h0, 32'(i * 4), 0, 0);
        bus_op(0, 4'h0, 32'h80, 0, 0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_ctrl("reset_ctrl", 4'b0000);
        check("reset_bus", {data_gnt_o, data_rvalid_o, data_err_o}, 0);
        check("reset_rdata", data_rdata_o, 0);
        next_cycle();

        // Slave port must stay silent outside recovery.
        data_req_i = 1; data_addr_i = 32'h14;
        @(negedge clk);
        check("idle_gnt", {31'd0, data_gnt_o}, 0);
        next_cycle();
        data_req_i = 0;
        @(negedge clk);
        check("idle_rvalid", {data_rvalid_o, data_err_o}, 0);
        next_cycle();

        run_commits(150, 1);
        // Matched x5 write with the final checkpoint PC.
        enable_i = 1; we_a_i = 1; we_b_i = 1; addr_a_i = 5; addr_b_i = 5;
        data_a_i = 32'h1234; data_b_i = 32'h1234; valid_instr_exec_i = 1; pc_i = 32'h40;
        next_cycle();
        m_regs[5] = 32'h1234; m_pc = 32'h40;
        quiet_core();
        @(negedge clk);
        check_ctrl("x5_commit_ctrl", 4'b0000);
        next_cycle();

        run_commits(30, 0);
        @(negedge clk);
        check_ctrl("disabled_ctrl", 4'b0000);
        next_cycle();

        enter_recovery(0, 5'd3, 32'h1, 32'h2);
        verify_all();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 0;
            bus_op(1'($urandom), 4'($urandom), a, $urandom, 0);
        end
        verify_all();
        bus_op(0, 4'h0, 32'h14, 0, 1);

        run_commits(50, 1);
        enter_recovery(1, 5'($urandom_range(1, 31)), 32'hCAFE_0001, 32'hCAFE_0001);
        verify_all();

        // Reset in the middle of recovery.
        rst_ni = 0;
        @(negedge clk);
        check_ctrl("pre_rst_ctrl", 4'b0011);
        next_cycle();
        rst_ni = 1;
        quiet_core();
        model_clear();
        @(negedge clk);
        check_ctrl("rst_mid_ctrl", 4'b0000);
        next_cycle();

        enter_recovery(1, 5'd0, 32'h0, 32'h0);
        bus_op(1, 4'b0011, 32'h08, 32'hFFFF_FFFF, 0);
        bus_op(0, 4'h0, 32'h08, 0, 0);
        bus_op(0, 4'h0, 32'h00, 0, 0);
        bus_op(0, 4'h0, 32'h84, 0, 0);
        bus_op(1, 4'hF, 32'h00, 32'hDEAD_BEEF, 0);
        bus_op(0, 4'h0, 32'h02, 0, 0);
        verify_all();
        bus_op(0, 4'h0, 32'h80, 0, 1);
        @(negedge clk);
        check_ctrl("final_ctrl", 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
